vx_uuid_alloc: RTL and testbench

- Multi-channel, parametrised UUID allocator for per-warp instruction/request tagging inside a core.
- Serves up to NUM_REQS independent allocation channels per cycle, each with a valid/ready handshake and a registered response.
- Keeps a per-warp counter of width CNTR_WIDTH with selectable wrap or saturate overflow mode and a per-warp clear for warp respawn.
- Sits between the warp scheduler/issue stages and downstream trace/debug consumers.

---
 rtl/vx_uuid_alloc_if.sv | 40 ++++
 rtl/vx_uuid_alloc.sv | 141 ++++++++++++++
 tb/tb_vx_uuid_alloc.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_uuid_alloc_if.sv
// Request/response bundle for the per-warp UUID allocator.
// Channel i of every vector occupies slice i.
interface vx_uuid_alloc_if #(
  parameter int NUM_REQS   = 2,
  parameter int NUM_WARPS  = 4,
  parameter int UUID_WIDTH = 44,
  parameter int WID_W      =
    (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS*WID_W-1:0]      req_wid;
  logic [NUM_REQS-1:0]            req_ready;
  logic [NUM_REQS-1:0]            rsp_valid;
  logic [NUM_REQS*UUID_WIDTH-1:0] rsp_uuid;
  logic [NUM_REQS-1:0]            rsp_ready;
  logic [NUM_WARPS-1:0]           clear_mask;
  logic [NUM_WARPS-1:0]           overflow;

  modport master (
    output req_valid,
    output req_wid,
    output rsp_ready,
    output clear_mask,
    input  req_ready,
    input  rsp_valid,
    input  rsp_uuid,
    input  overflow
  );

  modport slave (
    input  req_valid,
    input  req_wid,
    input  rsp_ready,
    input  clear_mask,
    output req_ready,
    output rsp_valid,
    output rsp_uuid,
    output overflow
  );
endinterface

// File: rtl/vx_uuid_alloc.sv
// Multi-channel per-warp UUID allocator.
// UUID = {global warp id, per-warp count}, one-cycle registered reply.
module vx_uuid_alloc #(
  parameter int CORE_ID    = 0,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REQS   = 2,
  parameter int UUID_WIDTH = 44,
  parameter int CNTR_WIDTH = 32,
  parameter int SATURATE   = 0
) (
  input  logic           clk,
  input  logic           reset,
  vx_uuid_alloc_if.slave bus
);
  localparam int WID_W =
    (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int GNW_W = UUID_WIDTH - CNTR_WIDTH;
  localparam int KW    = $clog2(NUM_REQS + 1);
  localparam int SW    = CNTR_WIDTH + KW;
  localparam int GSW   = GNW_W + 32;

  localparam logic [SW-1:0] MAXV =
    SW'({CNTR_WIDTH{1'b1}});
  localparam logic [GSW-1:0] GBASE =
    GSW'(CORE_ID * NUM_WARPS);

  logic [NUM_WARPS-1:0][CNTR_WIDTH-1:0] cnt_q;
  logic [NUM_WARPS-1:0][CNTR_WIDTH-1:0] cnt_d;
  logic [NUM_WARPS-1:0]                 ovf_q;
  logic [NUM_WARPS-1:0]                 ovf_d;
  logic [NUM_REQS-1:0]                  rsp_valid_q;
  logic [NUM_REQS-1:0]                  rsp_valid_d;
  logic [NUM_REQS-1:0][UUID_WIDTH-1:0]  rsp_uuid_q;
  logic [NUM_REQS-1:0][UUID_WIDTH-1:0]  rsp_uuid_d;

  logic [NUM_REQS-1:0]             acc;
  logic [NUM_REQS-1:0][WID_W-1:0]  wid;
  logic [NUM_REQS-1:0][KW-1:0]     rank;
  logic [NUM_REQS-1:0][SW-1:0]     sum_r;
  logic [NUM_WARPS-1:0][KW-1:0]    hits;
  logic [NUM_WARPS-1:0][SW-1:0]    base;
  logic [NUM_WARPS-1:0][SW-1:0]    sum_w;
  logic [NUM_WARPS-1:0]            ovf_new;

  function automatic logic [CNTR_WIDTH-1:0] fold(
    input logic [SW-1:0] s
  );
    if (SATURATE != 0 && s > MAXV)
      return {CNTR_WIDTH{1'b1}};
    return s[CNTR_WIDTH-1:0];
  endfunction

  function automatic logic [GNW_W-1:0] gid(
    input logic [WID_W-1:0] w
  );
    return GNW_W'(GBASE + GSW'(w));
  endfunction

  assign bus.req_ready = ~rsp_valid_q | bus.rsp_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_uuid  = rsp_uuid_q;
  assign bus.overflow  = ovf_q;

  assign acc = bus.req_valid & bus.req_ready;
  assign wid = bus.req_wid;

  // Same-warp requests in one cycle are ranked by channel index.
  always_comb begin
    rank = '0;
    hits = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      for (int j = 0; j < i; j++) begin
        if (acc[j] && wid[j] == wid[i])
          rank[i] = rank[i] + KW'(1);
      end
    end
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (acc[i] && wid[i] == WID_W'(w))
          hits[w] = hits[w] + KW'(1);
      end
    end
  end

  always_comb begin
    base = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (!bus.clear_mask[w])
        base[w] = SW'(cnt_q[w]);
    end
  end

  always_comb begin
    sum_r       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_uuid_d  = rsp_uuid_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      sum_r[i] = base[wid[i]] + SW'(rank[i]);
      if (acc[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_uuid_d[i]  =
          {gid(wid[i]), fold(sum_r[i])};
      end else if (bus.rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  // Overflow is judged on the post-allocation sum.
  always_comb begin
    sum_w   = '0;
    cnt_d   = cnt_q;
    ovf_new = '0;
    ovf_d   = ovf_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      sum_w[w] = base[w] + SW'(hits[w]);
      cnt_d[w] = fold(sum_w[w]);
      if (SATURATE != 0)
        ovf_new[w] = (hits[w] != '0) &&
                     (sum_w[w] >= MAXV);
      else
        ovf_new[w] = sum_w[w] > MAXV;
      ovf_d[w] = (ovf_q[w] & ~bus.clear_mask[w])
               | ovf_new[w];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      ovf_q       <= '0;
      rsp_valid_q <= '0;
      rsp_uuid_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_uuid_q  <= rsp_uuid_d;
    end
  end
endmodule

// File: tb/tb_vx_uuid_alloc.sv
// Bench for vx_uuid_alloc: three parameterisations share one stimulus,
// checked by directed vectors and a total-count reference model.
module tb_vx_uuid_alloc;
  localparam int NW = 4;
  localparam int NR = 2;
  localparam int WW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] rsp_ready;
  logic [NR*WW-1:0] req_wid;
  logic [NW-1:0] clear_mask;

  vx_uuid_alloc_if #(.NUM_REQS(NR), .NUM_WARPS(NW),
    .UUID_WIDTH(44)) b0 ();
  vx_uuid_alloc_if #(.NUM_REQS(NR), .NUM_WARPS(NW),
    .UUID_WIDTH(12)) b1 ();
  vx_uuid_alloc_if #(.NUM_REQS(NR), .NUM_WARPS(NW),
    .UUID_WIDTH(10)) b2 ();

  assign b0.req_valid  = req_valid;
  assign b0.req_wid    = req_wid;
  assign b0.rsp_ready  = rsp_ready;
  assign b0.clear_mask = clear_mask;
  assign b1.req_valid  = req_valid;
  assign b1.req_wid    = req_wid;
  assign b1.rsp_ready  = rsp_ready;
  assign b1.clear_mask = clear_mask;
  assign b2.req_valid  = req_valid;
  assign b2.req_wid    = req_wid;
  assign b2.rsp_ready  = rsp_ready;
  assign b2.clear_mask = clear_mask;

  vx_uuid_alloc #(.CORE_ID(1), .NUM_WARPS(NW),
    .NUM_REQS(NR), .UUID_WIDTH(44), .CNTR_WIDTH(32),
    .SATURATE(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  vx_uuid_alloc #(.CORE_ID(3), .NUM_WARPS(NW),
    .NUM_REQS(NR), .UUID_WIDTH(12), .CNTR_WIDTH(4),
    .SATURATE(0)) u1 (.clk(clk), .reset(reset), .bus(b1));
  vx_uuid_alloc #(.CORE_ID(70), .NUM_WARPS(NW),
    .NUM_REQS(NR), .UUID_WIDTH(10), .CNTR_WIDTH(4),
    .SATURATE(1)) u2 (.clk(clk), .reset(reset), .bus(b2));

  logic [NR-1:0] dv  [3];
  logic [NR-1:0] dr  [3];
  logic [NW-1:0] dov [3];
  logic [63:0]   du  [3][NR];

  assign dv[0]  = b0.rsp_valid;
  assign dv[1]  = b1.rsp_valid;
  assign dv[2]  = b2.rsp_valid;
  assign dr[0]  = b0.req_ready;
  assign dr[1]  = b1.req_ready;
  assign dr[2]  = b2.req_ready;
  assign dov[0] = b0.overflow;
  assign dov[1] = b1.overflow;
  assign dov[2] = b2.overflow;
  for (genvar i = 0; i < NR; i++) begin : g_u
    assign du[0][i] = 64'(b0.rsp_uuid[i*44 +: 44]);
    assign du[1][i] = 64'(b1.rsp_uuid[i*12 +: 12]);
    assign du[2][i] = 64'(b2.rsp_uuid[i*10 +: 10]);
  end

  int checks = 0;
  int fails  = 0;

  // Reference model: allocations since the last clear/reset per warp.
  longint tot [3][NW];
  bit     mv  [3][NR];
  longint mu  [3][NR];

  function automatic int core_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 70;
  endfunction
  function automatic int cw_of(int d);
    return (d == 0) ? 32 : 4;
  endfunction
  function automatic int uw_of(int d);
    return (d == 0) ? 44 : (d == 1) ? 12 : 10;
  endfunction
  function automatic bit sat_of(int d);
    return d == 2;
  endfunction

  function automatic longint maxc(int d);
    return (longint'(1) << cw_of(d)) - 1;
  endfunction
  function automatic longint cnt_of(int d, longint t);
    if (sat_of(d)) return (t > maxc(d)) ? maxc(d) : t;
    return t % (maxc(d) + 1);
  endfunction
  function automatic bit ovf_of(int d, longint t);
    if (sat_of(d)) return t >= maxc(d);
    return t > maxc(d);
  endfunction
  function automatic longint uuid_of(int d, int w, longint c);
    longint g;
    g = longint'(core_of(d) * NW + w)
      % (longint'(1) << (uw_of(d) - cw_of(d)));
    return (g << cw_of(d)) | c;
  endfunction

  task automatic chk(string nm, int d,
                     logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h want %0h",
               nm, d, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < NW; w++) tot[d][w] = 0;
      for (int i = 0; i < NR; i++) begin
        mv[d][i] = 0;
        mu[d][i] = 0;
      end
    end
  endtask

  task automatic model_step();
    longint nb [NW];
    bit acc;
    int w;
    if (reset) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < NW; k++)
        nb[k] = clear_mask[k] ? 0 : tot[d][k];
      for (int i = 0; i < NR; i++) begin
        acc = req_valid[i] && (!mv[d][i] || rsp_ready[i]);
        w = int'(req_wid[i*WW +: WW]);
        if (acc) begin
          mu[d][i] = uuid_of(d, w, cnt_of(d, nb[w]));
          nb[w]++;
          mv[d][i] = 1;
        end else if (rsp_ready[i]) begin
          mv[d][i] = 0;
        end
      end
      for (int k = 0; k < NW; k++) tot[d][k] = nb[k];
    end
  endtask

  task automatic check_dut(int d);
    logic [NR-1:0] ev, er;
    logic [NW-1:0] eo;
    for (int i = 0; i < NR; i++) begin
      ev[i] = mv[d][i];
      er[i] = !mv[d][i] || rsp_ready[i];
    end
    for (int w = 0; w < NW; w++)
      eo[w] = ovf_of(d, tot[d][w]);
    chk("rsp_valid", d, 64'(dv[d]), 64'(ev));
    chk("req_ready", d, 64'(dr[d]), 64'(er));
    chk("overflow", d, 64'(dov[d]), 64'(eo));
    for (int i = 0; i < NR; i++)
      if (mv[d][i]) chk("rsp_uuid", d, du[d][i], mu[d][i]);
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_dut(d);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       rst;
    bit [1:0] rv;
    bit [1:0] w0;
    bit [1:0] w1;
    bit [1:0] rr;
    bit [3:0] clr;
    bit [1:0] ev;
    int       g0;
    int       c0;
    int       g1;
    int       c1;
  } vec_t;

  vec_t tv [18];

  task automatic check_row(int r);
    vec_t v;
    v = tv[r];
    chk($sformatf("row%0d_valid", r), 0,
        64'(dv[0]), 64'(v.ev));
    if (v.ev[0])
      chk($sformatf("row%0d_uuid0", r), 0, du[0][0],
          (longint'(v.g0) << 32) | longint'(v.c0));
    if (v.ev[1])
      chk($sformatf("row%0d_uuid1", r), 0, du[0][1],
          (longint'(v.g1) << 32) | longint'(v.c1));
  endtask

  initial begin
    // rst rv w0 w1 rr clr | ev g0 c0 g1 c1  (dut0, CORE_ID=1)
    tv[0]  = '{0, 2'b01, 2, 0, 2'b11, 0, 2'b01, 6, 0, 0, 0};
    tv[1]  = '{0, 2'b01, 2, 0, 2'b11, 0, 2'b01, 6, 1, 0, 0};
    tv[2]  = '{0, 2'b11, 1, 1, 2'b11, 0, 2'b11, 5, 0, 5, 1};
    tv[3]  = '{0, 2'b10, 0, 1, 2'b11, 0, 2'b10, 0, 0, 5, 2};
    tv[4]  = '{0, 2'b01, 0, 0, 2'b11, 0, 2'b01, 4, 0, 0, 0};
    tv[5]  = '{0, 2'b01, 0, 0, 2'b10, 0, 2'b01, 4, 0, 0, 0};
    tv[6]  = '{0, 2'b01, 0, 0, 2'b10, 0, 2'b01, 4, 0, 0, 0};
    tv[7]  = '{0, 2'b01, 0, 0, 2'b10, 0, 2'b01, 4, 0, 0, 0};
    tv[8]  = '{0, 2'b01, 0, 0, 2'b11, 0, 2'b01, 4, 1, 0, 0};
    tv[9]  = '{0, 2'b11, 3, 3, 2'b11, 0, 2'b11, 7, 0, 7, 1};
    tv[10] = '{0, 2'b11, 3, 3, 2'b11, 0, 2'b11, 7, 2, 7, 3};
    tv[11] = '{0, 2'b01, 3, 0, 2'b11, 0, 2'b01, 7, 4, 0, 0};
    tv[12] = '{0, 2'b01, 3, 0, 2'b11, 8, 2'b01, 7, 0, 0, 0};
    tv[13] = '{0, 2'b01, 3, 0, 2'b11, 0, 2'b01, 7, 1, 0, 0};
    tv[14] = '{0, 2'b01, 3, 0, 2'b00, 0, 2'b01, 7, 1, 0, 0};
    tv[15] = '{1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0};
    tv[16] = '{0, 2'b01, 3, 0, 2'b11, 0, 2'b01, 7, 0, 0, 0};
    tv[17] = '{0, 2'b00, 0, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0};

    reset      = 1'b1;
    req_valid  = '0;
    req_wid    = '0;
    rsp_ready  = '0;
    clear_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset = 1'b0;

    for (int r = 0; r < 18; r++) begin
      reset      = tv[r].rst;
      req_valid  = tv[r].rv;
      req_wid    = {tv[r].w1, tv[r].w0};
      rsp_ready  = tv[r].rr;
      clear_mask = tv[r].clr;
      tick();
      check_row(r);
    end

    // 17 allocations on warp 0 across the 4-bit counter boundary
    reset      = 1'b1;
    req_valid  = '0;
    rsp_ready  = '1;
    clear_mask = '0;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      req_valid = 2'b01;
      req_wid   = '0;
      tick();
      if (n == 15) begin
        chk("ovf15_wrap", 1, 64'(dov[1][0]), 64'd0);
        chk("ovf15_sat", 2, 64'(dov[2][0]), 64'd1);
      end
      if (n >= 16) begin
        chk($sformatf("wrap_cnt%0d", n), 1,
            du[1][0] & 64'hf, (n == 16) ? 64'd15 : 64'd0);
        chk($sformatf("sat_cnt%0d", n), 2,
            du[2][0] & 64'hf, 64'd15);
      end
      if (n == 17) begin
        chk("ovf17_wrap", 1, 64'(dov[1][0]), 64'd1);
        chk("ovf17_sat", 2, 64'(dov[2][0]), 64'd1);
      end
    end
    req_valid  = '0;
    clear_mask = 4'b0001;
    tick();
    clear_mask = '0;
    chk("ovf_clr_wrap", 1, 64'(dov[1][0]), 64'd0);
    chk("ovf_clr_sat", 2, 64'(dov[2][0]), 64'd0);

    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      req_valid  = 2'($urandom);
      req_wid    = 4'($urandom);
      rsp_ready  = {$urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0};
      clear_mask = ($urandom_range(0, 31) == 0)
                 ? 4'($urandom) : 4'd0;
      tick();
    end
    reset      = 1'b0;
    req_valid  = '0;
    clear_mask = '0;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
